// File: rtl/mips_pc_pkg.sv
// rtl/mips_pc_pkg.sv - shared types and constants for the PC stage
package mips_pc_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } pc_state_t;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_JR   = 2'b01;
   localparam logic [1:0] CAUSE_BR   = 2'b10;
   localparam logic [1:0] CAUSE_J    = 2'b11;

   localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - decode-to-PC bus plus PC, fault and retire status
interface pc_unit_if;

   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        jump;
   logic [25:0] jump_index;
   logic        jr_control;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fault;
   logic [31:0] fault_pc;
   logic [1:0]  fault_cause;
   logic [31:0] retired_count;

   modport master (
      output stall, branch_taken, branch_offset, jump, jump_index, jr_control, jr_target,
      input  pc, pc_plus4, fault, fault_pc, fault_cause, retired_count
   );

   modport slave (
      input  stall, branch_taken, branch_offset, jump, jump_index, jr_control, jr_target,
      output pc, pc_plus4, fault, fault_pc, fault_cause, retired_count
   );

endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority mux, target arithmetic and alignment check
module pc_next_sel
   import mips_pc_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr_control,
   input  logic [31:0] jr_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] target,
   output logic        misaligned,
   output logic [1:0]  cause
);

   assign pc_plus4 = pc + PC_INC;

   // JR outranks jump so an illegal JR+J decode resolves silently to JR
   always_comb begin
      target = pc_plus4;
      cause  = CAUSE_NONE;
      if (jr_control) begin
         target = jr_target;
         cause  = CAUSE_JR;
      end else if (jump) begin
         target = {pc_plus4[31:28], jump_index, 2'b00};
         cause  = CAUSE_J;
      end else if (branch_taken) begin
         target = pc_plus4 + (branch_offset << 2);
         cause  = CAUSE_BR;
      end
   end

   assign misaligned = |target[1:0];

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - PC register, sticky misalignment trap and retire counter
module pc_unit
   import mips_pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic      clk,
   input  logic      reset,
   pc_unit_if.slave  bus
);

   pc_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] count_q, count_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [1:0]  cause_q, cause_d;

   logic [31:0] pc_plus4;
   logic [31:0] target;
   logic        misaligned;
   logic [1:0]  cause;

   pc_next_sel u_next_sel (
      .pc            (pc_q),
      .branch_taken  (bus.branch_taken),
      .branch_offset (bus.branch_offset),
      .jump          (bus.jump),
      .jump_index    (bus.jump_index),
      .jr_control    (bus.jr_control),
      .jr_target     (bus.jr_target),
      .pc_plus4      (pc_plus4),
      .target        (target),
      .misaligned    (misaligned),
      .cause         (cause)
   );

   // FAULT is terminal until reset; a stalled RUN cycle changes nothing
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      count_d    = count_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      cause_d    = cause_q;
      if (state_q == RUN && !bus.stall) begin
         if (misaligned) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            cause_d    = cause;
         end else begin
            pc_d    = target;
            count_d = count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         count_q    <= 32'd0;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'd0;
         cause_q    <= CAUSE_NONE;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
         cause_q    <= cause_d;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_plus4      = pc_plus4;
   assign bus.fault         = fault_q;
   assign bus.fault_pc      = fault_pc_q;
   assign bus.fault_cause   = cause_q;
   assign bus.retired_count = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed and randomized bench for pc_unit against a reference model
module tb_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic clk;
   logic reset;
   pc_unit_if bus ();

   pc_unit #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_pc;
   logic [31:0] exp_count;
   bit          exp_fault;
   logic [31:0] exp_fault_pc;
   logic [1:0]  exp_cause;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input bit rst, input bit st,
                       input bit bt, input logic [31:0] bo,
                       input bit j, input logic [25:0] ji,
                       input bit jr, input logic [31:0] jt);
      logic [31:0] p4, tgt;
      logic [1:0]  src;
      reset             = rst;
      bus.stall         = st;
      bus.branch_taken  = bt;
      bus.branch_offset = bo;
      bus.jump          = j;
      bus.jump_index    = ji;
      bus.jr_control    = jr;
      bus.jr_target     = jt;
      #1;
      if (!rst) chk({tag, ".pc_plus4"}, bus.pc_plus4, exp_pc + 32'd4);
      if (rst) begin
         exp_pc       = RST_PC;
         exp_count    = 0;
         exp_fault    = 0;
         exp_fault_pc = 0;
         exp_cause    = 0;
      end else if (!exp_fault && !st) begin
         p4 = exp_pc + 32'd4;
         if (jr) begin
            tgt = jt; src = 2'd1;
         end else if (j) begin
            tgt = (p4 & 32'hF000_0000) | (32'(ji) * 32'd4); src = 2'd3;
         end else if (bt) begin
            tgt = p4 + bo * 32'd4; src = 2'd2;
         end else begin
            tgt = p4; src = 2'd0;
         end
         if (tgt % 4 != 0) begin
            exp_fault    = 1;
            exp_fault_pc = exp_pc;
            exp_cause    = src;
         end else begin
            exp_pc    = tgt;
            exp_count = exp_count + 1;
         end
      end
      @(posedge clk);
      #1;
      chk({tag, ".pc"}, bus.pc, exp_pc);
      chk({tag, ".count"}, bus.retired_count, exp_count);
      chk({tag, ".fault"}, {31'd0, bus.fault}, {31'd0, exp_fault});
      chk({tag, ".fault_pc"}, bus.fault_pc, exp_fault_pc);
      chk({tag, ".cause"}, {30'd0, bus.fault_cause}, {30'd0, exp_cause});
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0);
   endtask

   initial begin
      logic [31:0] r, jt;
      bit rst, st, bt, j, jr;

      exp_pc = RST_PC; exp_count = 0; exp_fault = 0; exp_fault_pc = 0; exp_cause = 0;
      @(posedge clk);
      #1;

      // reset then sequential fetch
      step("reset", 1, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0);
      chk("reset_pc_const", bus.pc, 32'h0040_0000);
      idle("seq1");
      idle("seq2");
      idle("seq3");
      chk("seq3_pc_const", bus.pc, 32'h0040_000C);
      chk("seq3_count_const", bus.retired_count, 32'd3);
      idle("seq4");

      // backward branch then jump
      step("branch", 0, 0, 1, 32'hFFFF_FFFC, 0, 26'd0, 0, 32'd0);
      chk("branch_pc_const", bus.pc, 32'h0040_0004);
      step("jump", 0, 0, 0, 32'd0, 1, 26'h0100000, 0, 32'd0);
      chk("jump_pc_const", bus.pc, 32'h0040_0000);

      // JR priority over jump
      step("jr_to20", 0, 0, 0, 32'd0, 0, 26'd0, 1, 32'h0040_0020);
      step("jr_prio", 0, 0, 1, 32'd8, 1, 26'h3FFFFFF, 1, 32'h0040_1000);
      chk("jr_prio_pc_const", bus.pc, 32'h0040_1000);

      // misaligned JR trap, then frozen under random inputs
      step("jr_to30", 0, 0, 0, 32'd0, 0, 26'd0, 1, 32'h0040_0030);
      step("jr_misal", 0, 0, 0, 32'd0, 0, 26'd0, 1, 32'h0040_0002);
      chk("fault_const", {31'd0, bus.fault}, 32'd1);
      chk("fault_pc_const", bus.fault_pc, 32'h0040_0030);
      chk("fault_cause_const", {30'd0, bus.fault_cause}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         r = $urandom;
         step("frozen", 0, r[0], r[1], $urandom, r[2], 26'($urandom), r[3], $urandom);
      end
      step("reset_fault", 1, 1, 0, 32'd0, 0, 26'd0, 1, 32'h0000_0001);
      chk("reset_fault_const", {31'd0, bus.fault}, 32'd0);

      // sequential wrap and stall hold
      step("jr_top", 0, 0, 0, 32'd0, 0, 26'd0, 1, 32'hFFFF_FFFC);
      idle("wrap");
      chk("wrap_pc_const", bus.pc, 32'h0000_0000);
      for (int i = 0; i < 4; i++)
         step("stall", 0, 1, 0, 32'd0, 1, 26'h0ABCDEF, 0, 32'd0);

      // reset during stall
      step("reset_stall", 1, 1, 0, 32'd0, 0, 26'd0, 0, 32'd0);
      chk("reset_stall_pc_const", bus.pc, RST_PC);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         r  = $urandom;
         rst = ($urandom_range(0, 29) == 0);
         st  = ($urandom_range(0, 3) == 0);
         bt  = r[0];
         j   = ($urandom_range(0, 3) == 0);
         jr  = ($urandom_range(0, 3) == 0);
         jt  = $urandom;
         if ($urandom_range(0, 7) != 0) jt[1:0] = 2'b00;
         step("rand", rst, st, bt, $urandom, j, 26'($urandom), jr, jt);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the single-cycle MIPS core, directly downstream of the JR decode signal: it consumes `JRControl`, branch and jump decisions each cycle, selects the next instruction address, and holds it in the PC register that drives instruction memory. It also traps misaligned targets into a sticky fault state and counts retired instructions for the SoC debug block.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1: single core clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold request from the memory/bus side; freezes all state.
- `branch_taken`  in  1: beq/bne condition met (Branch & Zero resolved upstream).
- `branch_offset`  in  32: sign-extended imm16, in words (not yet shifted).
- `jump`  in  1: J-type jump decoded.
- `jump_index`  in  26: instr[25:0].
- `jr_control`  in  1: JR decoded (ALUOp = 2'b10 and funct = 6'b001000).
- `jr_target`  in  32: reg[rs] read data.
- `pc`  out  32: current PC, registered; drives instruction memory address.
- `pc_plus4`  out  32: pc + 4, combinational; also used as link address.
- `fault`  out  1: registered; misaligned-target trap taken, sticky.
- `fault_pc`  out  32: registered; PC of the instruction whose target faulted.
- `fault_cause`  out  2: registered; 2'b00 none, 2'b01 JR, 2'b10 branch, 2'b11 jump.
- `retired_count`  out  32: registered; count of accepted PC updates.

## Operation
- Two states: RUN, FAULT.
- Next-PC selection, fixed priority: JR > jump > branch > sequential.
  - JR target = `jr_target`.
  - Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
  - Branch target = pc_plus4 + (branch_offset << 2), 32-bit modular add; overflow wraps, no flag.
  - Sequential = pc_plus4, modular: pc 32'hFFFF_FFFC -> 32'h0000_0000.
- Simultaneous `jr_control` and `jump` (illegal decode): JR wins, no error raised.
- Alignment check applies only to the selected target. JR is the only source that can be misaligned; jump and branch targets are aligned by construction. The check is still applied uniformly.
- RUN, `stall`=0, target[1:0]==0:
  - pc <= target.
  - retired_count <= retired_count + 1, wrapping at 2^32.
- RUN, `stall`=0, target[1:0]!=0:
  - pc unchanged.
  - fault <= 1, fault_pc <= pc, fault_cause <= source code.
  - State -> FAULT; retired_count unchanged.
- RUN, `stall`=1: all state held; decode inputs ignored for that cycle.
- FAULT: pc, count and fault registers frozen regardless of inputs. Only reset exits.

## Timing
- Reset (sampled at posedge while `reset`=1):
  - pc = RESET_PC, state RUN.
  - fault = 0, fault_pc = 0, fault_cause = 2'b00, retired_count = 0.
- `reset` has priority over `stall` and over the FAULT state; reset mid-fault clears the fault in one edge.
- Next-PC path is combinational from inputs to pc D-input; one-cycle latency from decode to new `pc`.
- `pc_plus4` is valid in the same cycle as `pc`; no registered copy.
- `fault` asserts on the edge following the offending cycle and stays high until reset.
- `stall` is level-sensitive and has no handshake; a stalled cycle is not counted.

## Structure
- Shared package `mips_pc_pkg`:
  - state enum {RUN, FAULT}.
  - cause constants CAUSE_NONE / CAUSE_JR / CAUSE_BR / CAUSE_J.
  - PC_INC = 32'd4.
- One combinational sub-module, `pc_next_sel`: priority mux, target arithmetic, alignment check, cause encode.
- `pc_unit` holds the registers and FSM.

## Test plan
- Reset with RESET_PC=32'h0040_0000, then 3 idle cycles -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C; retired_count = 3.
- At pc=0x00400010: branch_taken=1, branch_offset=32'hFFFF_FFFC -> next pc 0x00400004. Then jump=1, jump_index=26'h0100000 -> pc 0x00400000.
- At pc=0x00400020: jr_control=1, jump=1, jr_target=0x00401000 -> pc 0x00401000 (JR priority).
- At pc=0x00400030: jr_control=1, jr_target=0x00400002 -> fault=1, fault_pc=0x00400030, fault_cause=2'b01. pc and count stay frozen for 10 cycles of any input; reset then clears all.
- pc=0xFFFF_FFFC, no control -> pc 0x00000000. Hold stall=1 for 4 cycles with jump asserted -> pc and retired_count unchanged.
- Assert reset while stall=1 in RUN -> pc = RESET_PC on the next edge.
